fifo_canal: RTL and testbench

- Synchronous single-clock FIFO buffering one traffic channel.
- Four instances feed the arbiter: the arbiter samples `empty` and drives `pop`.
- Four more instances receive the arbiter's routed words: the arbiter samples `full` and drives `push`.
- Provides registered read data, occupancy count, almost-full/almost-empty flow-control flags and sticky overflow/underflow error flags.

---
 rtl/fifo_canal.sv | 92 +++++++++
 tb/tb_fifo_canal.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_canal.sv
// fifo_canal: single-clock FIFO buffering one traffic channel toward or from
// the arbiter. Registered read data, occupancy count, almost-full/almost-empty
// flow-control flags and sticky overflow/underflow error flags.
module fifo_canal #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  error_overflow,
   output logic                  error_underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Thresholds sized to the count so the flag decodes compare like widths.
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_en;
   logic                  rd_en;

   // Flags decode the registered count directly, so they carry no extra latency.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A read needs a stored word. A write needs room, or a same-edge read that
   // frees the slot; with an empty FIFO the pop is rejected, so the pushed
   // word never falls through to data_out on the same edge.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   // Storage array: capture the incoming word at the write pointer.
   // NOTE: the array has no reset branch; stale contents are unreachable once
   // the pointers clear, and leaving it out lets synthesis map it to plain
   // registers or RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (wr_en && !reset)
         mem[wr_ptr] <= data_in;
   end

   // Pointers, occupancy, read register and sticky error flags.
   // NOTE: every state update uses <= so all registers see pre-edge values,
   // which the same-edge push/pop cases rely on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         data_out        <= '0;
         error_overflow  <= 1'b0;
         error_underflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;

         if (rd_en) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end

         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (push && full && !pop)
            error_overflow <= 1'b1;
         if (pop && empty)
            error_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_canal.sv
// tb_fifo_canal: directed and randomized stimulus against a queue-based
// reference model; read words go through a scoreboard queue that a separate
// monitor drains and compares, alongside per-cycle flag/count checks.
module tb_fifo_canal;

   localparam int DW    = 6;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          error_overflow, error_underflow;

   fifo_canal #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk             (clk),
      .reset           (reset),
      .push            (push),
      .pop             (pop),
      .data_in         (data_in),
      .data_out        (data_out),
      .full            (full),
      .empty           (empty),
      .almost_full     (almost_full),
      .almost_empty    (almost_empty),
      .count           (count),
      .error_overflow  (error_overflow),
      .error_underflow (error_underflow)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue, plus last word read and error state.
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model_last;
   bit            model_ovf;
   bit            model_unf;
   bit            mon_en;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      model_q.delete();
      exp_q.delete();
      model_last = '0;
      model_ovf  = 0;
      model_unf  = 0;
   endtask

   // One clock: present inputs, let the edge happen, apply FIFO rules to the model.
   task automatic cycle(input bit p, input bit q, input logic [DW-1:0] d);
      bit rd, wr;
      int sz;
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      sz = model_q.size();
      rd = q && (sz > 0);
      wr = p && ((sz < DEPTH) || rd);
      if (p && sz == DEPTH && !q) model_ovf = 1;
      if (q && sz == 0)           model_unf = 1;
      if (rd) begin
         model_last = model_q.pop_front();
         exp_q.push_back(model_last);
      end
      if (wr) model_q.push_back(d);
      #2;
   endtask

   // Monitor: every cycle compare status against the model; whenever a read
   // is owed, pop the scoreboard and compare the presented word.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("count", count, model_q.size());
         check("empty", empty, model_q.size() == 0);
         check("full", full, model_q.size() == DEPTH);
         check("almost_full", almost_full, model_q.size() >= AF);
         check("almost_empty", almost_empty, model_q.size() <= AE);
         check("error_overflow", error_overflow, model_ovf);
         check("error_underflow", error_underflow, model_unf);
         check("data_out_hold", data_out, model_last);
         if (exp_q.size() > 0)
            check("read_word", data_out, exp_q.pop_front());
      end
   end

   // Assert reset between edges and check the outputs clear without a clock.
   task automatic async_reset(input bit p, input logic [DW-1:0] d);
      push    = p;
      pop     = 1'b0;
      data_in = d;
      reset   = 1'b1;
      #1;
      model_clear();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_almost_empty", almost_empty, 1);
      check("rst_full", full, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_data_out", data_out, 0);
      check("rst_errors", {error_overflow, error_underflow}, 0);
      #4;
      reset = 1'b0;
      push  = 1'b0;
      @(posedge clk);
      #2;
   endtask

   initial begin
      mon_en  = 0;
      reset   = 1'b1;
      push    = 1'b1;
      pop     = 1'b1;
      data_in = 6'h2B;
      model_clear();
      // Edges while reset is high must ignore push/pop.
      repeat (2) @(posedge clk);
      #2;
      mon_en = 1;
      reset  = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      @(posedge clk);
      #2;

      // Fill 0x01..0x08 then drain; second round exercises pointer wrap.
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= 8; i++) cycle(1, 0, DW'(i));
         if (r == 1) begin
            cycle(1, 0, 6'h3F);          // overflow: dropped
            cycle(0, 0, 6'h00);
         end
         for (int i = 0; i < 8; i++) cycle(0, 1, 6'h00);
      end

      // Underflow on empty.
      cycle(0, 1, 6'h00);
      cycle(0, 0, 6'h00);

      // Push+pop at full.
      for (int i = 0; i < 8; i++) cycle(1, 0, DW'(6'h10 + i));
      cycle(1, 1, 6'h2A);
      for (int i = 0; i < 8; i++) cycle(0, 1, 6'h00);

      // Push+pop at empty: underflow, no fall-through, word comes out later.
      cycle(1, 1, 6'h15);
      cycle(0, 0, 6'h00);
      cycle(0, 1, 6'h00);

      // Mid-stream reset with count=5 and push asserted.
      for (int i = 0; i < 5; i++) cycle(1, 0, DW'(6'h20 + i));
      async_reset(1, 6'h33);
      cycle(1, 0, 6'h07);
      cycle(0, 1, 6'h00);

      // Randomized traffic with shifting push/pop bias.
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = (i / 100) % 3;
         case (bias)
            0: cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, DW'($urandom));
            1: cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, DW'($urandom));
            default: cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom));
         endcase
      end

      cycle(0, 0, 6'h00);
      check("scoreboard_drained", exp_q.size(), 0);
      async_reset(0, 6'h00);
      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
